// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetch stage feeding the Decoder
// One outstanding memory request, one-entry output register, flush redirect via DROP.
module instr_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_instr,
  output logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_addr_out,
  input  logic        dec_accept,
  input  logic        instr_issued,
  input  logic [31:0] predict_pc,
  input  logic        rob_clear,
  input  logic [31:0] clear_pc
);

  typedef enum logic [2:0] {
    S_REQ     = 3'd0,
    S_WAIT    = 3'd1,
    S_HOLD    = 3'd2,
    S_WAIT_PC = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        instr_ready_q, instr_ready_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_addr_out_q, instr_addr_out_d;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    mem_req_d        = mem_req_q;
    mem_addr_d       = mem_addr_q;
    instr_ready_d    = instr_ready_q;
    instr_out_d      = instr_out_q;
    instr_addr_out_d = instr_addr_out_q;
    if (rdy) begin
      if (rob_clear) begin
        // A request still in flight must be drained before the new PC can be fetched.
        pc_d          = clear_pc;
        instr_ready_d = 1'b0;
        if (mem_req_q && !mem_valid) begin
          state_d = S_DROP;
        end else begin
          mem_req_d = 1'b0;
          state_d   = S_REQ;
        end
      end else begin
        case (state_q)
          S_REQ: begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_WAIT;
          end
          S_WAIT: begin
            if (mem_valid) begin
              mem_req_d        = 1'b0;
              instr_out_d      = mem_instr;
              instr_addr_out_d = pc_q;
              instr_ready_d    = 1'b1;
              state_d          = S_HOLD;
            end
          end
          S_HOLD: begin
            if (dec_accept) begin
              instr_ready_d = 1'b0;
              state_d       = S_WAIT_PC;
            end
          end
          S_WAIT_PC: begin
            if (instr_issued) begin
              pc_d    = predict_pc;
              state_d = S_REQ;
            end
          end
          S_DROP: begin
            if (mem_valid) begin
              mem_req_d = 1'b0;
              state_d   = S_REQ;
            end
          end
          default: state_d = S_REQ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_REQ;
      pc_q             <= RESET_PC;
      mem_req_q        <= 1'b0;
      mem_addr_q       <= 32'h0;
      instr_ready_q    <= 1'b0;
      instr_out_q      <= 32'h0;
      instr_addr_out_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      mem_req_q        <= mem_req_d;
      mem_addr_q       <= mem_addr_d;
      instr_ready_q    <= instr_ready_d;
      instr_out_q      <= instr_out_d;
      instr_addr_out_q <= instr_addr_out_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign instr_ready    = instr_ready_q;
  assign instr_out      = instr_out_q;
  assign instr_addr_out = instr_addr_out_q;

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - directed and randomized checks of instr_fetcher
// Reference model tracks fetch transactions as flags: pending request, in-flight, discard, presented, awaiting issue.
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_instr = 32'h0;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_addr_out;
  logic        dec_accept = 1'b0;
  logic        instr_issued = 1'b0;
  logic [31:0] predict_pc = 32'h0;
  logic        rob_clear = 1'b0;
  logic [31:0] clear_pc = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc, m_addr, m_iout, m_iaddr;
  bit          m_need_req, m_inflight, m_discard, m_presented, m_awaiting;

  always #5 clk = ~clk;

  instr_fetcher #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_addr_out(instr_addr_out),
    .dec_accept(dec_accept), .instr_issued(instr_issued), .predict_pc(predict_pc),
    .rob_clear(rob_clear), .clear_pc(clear_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_iout = 32'h0; m_iaddr = 32'h0;
    m_need_req = 1; m_inflight = 0; m_discard = 0; m_presented = 0; m_awaiting = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (rdy) begin
      if (rob_clear) begin
        m_pc = clear_pc;
        m_presented = 0;
        m_awaiting = 0;
        if (m_inflight && !mem_valid) begin
          m_discard = 1;
        end else begin
          m_inflight = 0;
          m_discard = 0;
          m_need_req = 1;
        end
      end else if (m_need_req) begin
        m_need_req = 0;
        m_inflight = 1;
        m_addr = m_pc;
      end else if (m_inflight && mem_valid) begin
        m_inflight = 0;
        if (m_discard) begin
          m_discard = 0;
          m_need_req = 1;
        end else begin
          m_presented = 1;
          m_iout = mem_instr;
          m_iaddr = m_pc;
        end
      end else if (m_presented && dec_accept) begin
        m_presented = 0;
        m_awaiting = 1;
      end else if (m_awaiting && instr_issued) begin
        m_awaiting = 0;
        m_pc = predict_pc;
        m_need_req = 1;
      end
    end
  endtask

  task automatic check_model();
    check("mem_req", {31'h0, mem_req}, {31'h0, m_inflight});
    check("mem_addr", mem_addr, m_addr);
    check("instr_ready", {31'h0, instr_ready}, {31'h0, m_presented});
    check("instr_out", instr_out, m_iout);
    check("instr_addr_out", instr_addr_out, m_iaddr);
  endtask

  // one clock: DUT and model consume the same inputs, outputs compared at the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
    mem_valid = 0; dec_accept = 0; instr_issued = 0; rob_clear = 0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check("reset_mem_req", {31'h0, mem_req}, 32'h0);
    check("reset_ready", {31'h0, instr_ready}, 32'h0);
    tick();
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", mem_addr, 32'h0);

    // basic flow
    mem_valid = 1; mem_instr = 32'h00500093; tick();
    check("basic_ready", {31'h0, instr_ready}, 32'h1);
    check("basic_instr", instr_out, 32'h00500093);
    check("basic_iaddr", instr_addr_out, 32'h0);
    dec_accept = 1; tick();
    check("accept_drop_ready", {31'h0, instr_ready}, 32'h0);
    instr_issued = 1; predict_pc = 32'h4; tick();
    tick();
    check("next_addr", mem_addr, 32'h4);

    // decoder stall in HOLD
    mem_valid = 1; mem_instr = 32'h12345678; tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ready", {31'h0, instr_ready}, 32'h1);
      check("stall_instr", instr_out, 32'h12345678);
      check("stall_req", {31'h0, mem_req}, 32'h0);
    end
    dec_accept = 1; tick();
    instr_issued = 1; predict_pc = 32'h8; tick();
    tick();
    check("wait_addr8", mem_addr, 32'h8);

    // flush with request in flight
    rob_clear = 1; clear_pc = 32'h100; tick();
    check("drop_req_held", {31'h0, mem_req}, 32'h1);
    check("drop_addr_held", mem_addr, 32'h8);
    tick(); tick();
    mem_valid = 1; mem_instr = 32'hDEADBEEF; tick();
    check("drop_no_ready", {31'h0, instr_ready}, 32'h0);
    check("drop_req_off", {31'h0, mem_req}, 32'h0);
    tick();
    check("redirect_addr", mem_addr, 32'h100);

    // issue and flush in the same cycle
    mem_valid = 1; mem_instr = 32'h0000_0013; tick();
    dec_accept = 1; tick();
    instr_issued = 1; predict_pc = 32'h20; rob_clear = 1; clear_pc = 32'h40; tick();
    tick();
    check("clear_wins", mem_addr, 32'h40);

    // rdy low freezes everything
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1; mem_instr = 32'hCAFEF00D; tick();
      check("frozen_ready", {31'h0, instr_ready}, 32'h0);
      check("frozen_req", {31'h0, mem_req}, 32'h1);
    end
    rdy = 1; tick();
    check("unfrozen_wait", {31'h0, mem_req}, 32'h1);

    // async reset mid-WAIT
    rst = 1; #1;
    model_reset();
    check("async_rst_req", {31'h0, mem_req}, 32'h0);
    check("async_rst_addr", mem_addr, 32'h0);
    tick();
    rst = 0; tick();
    check("post_rst_req", {31'h0, mem_req}, 32'h1);
    check("post_rst_addr", mem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      mem_valid    = ($urandom_range(0, 9) < 3);
      mem_instr    = $urandom;
      dec_accept   = ($urandom_range(0, 1) == 1);
      instr_issued = ($urandom_range(0, 9) < 4);
      predict_pc   = $urandom;
      rob_clear    = ($urandom_range(0, 19) == 0);
      clear_pc     = $urandom;
      rst          = ($urandom_range(0, 299) == 0);
      tick();
      rst = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
